rvc_fetch_aligner: RTL
======================

// Module: rvc_fetch_aligner
// PURPOSE
//  Fetch-side stage between the pipeline fetch port and the I-cache. Turns halfword-aligned PCs into
//  32-bit instructions: it keeps the last cache word plus the previous word's upper half, stitches
//  32-bit instructions that straddle words, and expands 16-bit RVC instructions via rvc_expander.
//  It owns the I-cache proc_* handshake and holds the address stable during misses.
// PARAMETERS
//  NOP_INST  32'h0000_0013  substitute instruction emitted for illegal/unsupported 16-bit encodings
// PORTS
//  clk            in   1   clock, all state on rising edge
//  proc_reset     in   1   synchronous, active-high reset
//  fetch_req      in   1   core requests the instruction at fetch_pc
//  fetch_pc       in   32  byte PC; bit0 ignored, bit1 selects halfword
//  flush          in   1   invalidate buffered words (fence.i / redirect)
//  fetch_valid    out  1   fetch_inst/is_rvc/illegal valid this cycle
//  fetch_stall    out  1   core must hold fetch_pc and fetch_req
//  fetch_inst     out  32  32-bit (expanded) instruction
//  fetch_is_rvc   out  1   1: 16-bit source, core advances PC by 2; else by 4
//  fetch_illegal  out  1   16-bit encoding unsupported; fetch_inst = NOP_INST
//  ICACHE_ren     out  1   cache read request
//  ICACHE_wen     out  1   tied 0
//  ICACHE_addr    out  30  word address
//  ICACHE_wdata   out  32  tied 0
//  ICACHE_rdata   in   32  valid in any cycle with ren=1 and stall=0
//  ICACHE_stall   in   1   miss in progress; addr/ren must stay constant
// BEHAVIOUR
//  - Regs: buf_v/buf_tag[29:0]/buf_word[31:0]; prev_v/prev_tag/prev_hi[15:0]; pend_addr; discard; state.
//  - Reset: state S_IDLE, buf_v=prev_v=discard=0; in reset cycle ren=0, fetch_valid=0, fetch_stall=0.
//  - W = fetch_pc[31:2]; W1 = W+1 (30-bit, wraps 3FFF_FFFF->0). h = pc[1] ? word[31:16] : word[15:0].
//  - Need: h[1:0]!=2'b11 -> 16-bit from word W; pc[1]=0 and 32-bit -> word W; pc[1]=1 and 32-bit -> W[31:16] + W1[15:0].
//  - Source for W: buffer if buf_v&&buf_tag==W, else cache access. Straddle low half: prev_v&&prev_tag==W
//    &&buf_v&&buf_tag==W1 served fully from regs; if buffer hits W, cache accessed at W1; else access W first.
//  - At most one cache access per cycle; ren=1 only when fetch_req&&!flush and a needed word is not buffered.
//  - Cache hit (ren=1, stall=0): rdata bypassed combinationally into stitch/expander, fetch_valid=1 same
//    cycle; buf_word/tag <= rdata/addr, prev_* <= old buf_* (prev_hi=buf_word[31:16]).
//  - Straddle with W missing: cycle1 fetch W into buffer (fetch_stall=1), cycle2 fetch W1 and deliver.
//  - fetch_stall = fetch_req & !fetch_valid. fetch_valid=0 whenever fetch_req=0.
//  - FSM: S_IDLE (buf_v=0) / S_READY (buf_v=1) / S_WAIT. From IDLE/READY: ren&&stall -> latch pend_addr, S_WAIT.
//    S_WAIT: ren=1, addr=pend_addr regardless of fetch_pc; fetch_valid=0; on stall=0 write buffer (unless discard),
//    go S_READY (S_IDLE if discarded); no delivery in completion cycle, delivery earliest next cycle.
//  - flush: buf_v=prev_v<=0 next edge; same-cycle fetch_valid=0, ren not issued from IDLE/READY; in S_WAIT
//    sets discard, access still completes (handshake never aborted except by reset).
//  - Reset mid-S_WAIT: return to S_IDLE, ren drops next cycle (cache shares proc_reset).
//  - Expander (combinational): RV32C ADDI/LI/LUI/ADDI16SP/ADDI4SPN/NOP/SLLI/SRLI/SRAI/ANDI/SUB/XOR/OR/AND/
//    MV/ADD/J/JAL/JR/JALR/BEQZ/BNEZ/LW/SW/LWSP/SWSP/EBREAK; all others (incl. 16'h0000) -> NOP_INST, illegal=1.
//  - 32-bit instructions pass through unmodified.
// STRUCTURE
//  - rvc_defs.vh: quadrant/funct3 codes, base opcodes (OP_IMM, LUI, JAL, JALR, BRANCH, LOAD, STORE, OP),
//    state encodings S_IDLE/S_READY/S_WAIT, NOP_INST default.
//  - Sub-module rvc_expander (in[15:0] -> out[31:0], illegal); aligner = buffer, FSM, mux, handshake.
// TESTING
//  - Reset, pc=0x0, rdata=0x4501_0505 hit -> valid, inst=0x0015_0513, rvc=1; pc=0x2 -> inst=0x0000_0513, ren=0.
//  - pc=0x100, rdata=0x00A0_0093 -> inst=0x00A0_0093 unchanged, rvc=0, ICACHE_addr=0x40.
//  - Words 0x100=0x0093_0001, 0x104=0xABCD_00A0: pc 0x100 -> 0x0000_0013 rvc; pc 0x102 -> addr=0x41,
//    inst=0x00A0_0093, rvc=0; afterward buf_tag=0x41, prev_tag=0x40, refetch of 0x102 needs no ren.
//  - Miss at 0x50, stall=1 3 cycles, fetch_pc changed mid-wait -> addr held 0x50, stall=1, valid=0 through
//    completion; valid next cycle if pc word=0x50.
//  - flush during S_WAIT -> data discarded, next req of same word re-issues ren; pc=0xFFFF_FFFE 32-bit -> addr 0.
//  - Halfword 0x0000 -> illegal=1, inst=0x0000_0013, rvc=1; reset asserted in S_WAIT -> ren=0 next cycle.

Source files
------------

// File: rtl/rvc_fetch_aligner_pkg.sv
// Shared encodings for the RVC fetch aligner: opcodes, funct3,
// quadrants, FSM states and instruction encoder helpers.
package rvc_fetch_aligner_pkg;

  localparam logic [31:0] NOP_DEFAULT = 32'h0000_0013;

  localparam logic [1:0] Q0 = 2'b00;
  localparam logic [1:0] Q1 = 2'b01;
  localparam logic [1:0] Q2 = 2'b10;

  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_JAL    = 7'h6f;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLL = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_XOR = 3'b100;
  localparam logic [2:0] F3_SRL = 3'b101;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [2:0] F3_BNE = 3'b001;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_READY = 2'd1,
    S_WAIT  = 2'd2
  } state_e;

  function automatic logic [31:0] enc_i(
    input logic [11:0] imm,
    input logic [4:0]  rs1,
    input logic [2:0]  f3,
    input logic [4:0]  rd,
    input logic [6:0]  opc
  );
    return {imm, rs1, f3, rd, opc};
  endfunction

  function automatic logic [31:0] enc_s(
    input logic [11:0] imm,
    input logic [4:0]  rs2,
    input logic [4:0]  rs1,
    input logic [2:0]  f3,
    input logic [6:0]  opc
  );
    return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
  endfunction

  function automatic logic [31:0] enc_b(
    input logic [12:1] imm,
    input logic [4:0]  rs2,
    input logic [4:0]  rs1,
    input logic [2:0]  f3
  );
    return {imm[12], imm[10:5], rs2, rs1, f3,
            imm[4:1], imm[11], OPC_BRANCH};
  endfunction

  function automatic logic [31:0] enc_j(
    input logic [20:1] imm,
    input logic [4:0]  rd
  );
    return {imm[20], imm[10:1], imm[11],
            imm[19:12], rd, OPC_JAL};
  endfunction

endpackage

// File: rtl/rvc_fetch_aligner_expander.sv
// RV32C to RV32I expander; unsupported encodings become the
// substitute instruction with illegal raised.
module rvc_fetch_aligner_expander
  import rvc_fetch_aligner_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_DEFAULT
) (
  input  logic [15:0] half,
  output logic [31:0] inst,
  output logic        illegal
);

  logic [2:0]  f3;
  logic [4:0]  rd, rs2, rdp, rs1p, shamt;
  logic [11:0] imm6;
  logic [9:0]  i4spn, i16sp;
  logic [6:0]  ulw;
  logic [11:1] jimm;
  logic [8:1]  bimm;
  logic [7:0]  ulwsp, uswsp;
  logic [31:0] res;
  logic        bad;

  assign f3    = half[15:13];
  assign rd    = half[11:7];
  assign rs2   = half[6:2];
  assign rdp   = {2'b01, half[4:2]};
  assign rs1p  = {2'b01, half[9:7]};
  assign shamt = half[6:2];
  assign imm6  = {{6{half[12]}}, half[12], half[6:2]};
  assign i4spn = {half[10:7], half[12:11],
                  half[5], half[6], 2'b00};
  assign i16sp = {half[12], half[4:3], half[5],
                  half[2], half[6], 4'b0000};
  assign ulw   = {half[5], half[12:10], half[6], 2'b00};
  assign jimm  = {half[12], half[8], half[10:9], half[6],
                  half[7], half[2], half[11], half[5:3]};
  assign bimm  = {half[12], half[6:5], half[2],
                  half[11:10], half[4:3]};
  assign ulwsp = {half[3:2], half[12], half[6:4], 2'b00};
  assign uswsp = {half[8:7], half[12:9], 2'b00};

  always_comb begin
    res = '0;
    bad = 1'b0;
    unique case (half[1:0])
      Q0: begin
        unique case (f3)
          3'b000: begin
            bad = (i4spn == '0);
            res = enc_i({2'b00, i4spn}, 5'd2, F3_ADD,
                        rdp, OPC_OP_IMM);
          end
          3'b010: res = enc_i({5'b0, ulw}, rs1p, F3_LW,
                              rdp, OPC_LOAD);
          3'b110: res = enc_s({5'b0, ulw}, rdp, rs1p,
                              F3_LW, OPC_STORE);
          default: bad = 1'b1;
        endcase
      end
      Q1: begin
        unique case (f3)
          3'b000: res = enc_i(imm6, rd, F3_ADD,
                              rd, OPC_OP_IMM);
          3'b001: res = enc_j({{9{jimm[11]}}, jimm}, 5'd1);
          3'b010: res = enc_i(imm6, 5'd0, F3_ADD,
                              rd, OPC_OP_IMM);
          3'b011: begin
            if (rd == 5'd2) begin
              bad = (i16sp == '0);
              res = enc_i({{2{i16sp[9]}}, i16sp}, 5'd2,
                          F3_ADD, 5'd2, OPC_OP_IMM);
            end else begin
              bad = (imm6 == '0);
              res = {{14{half[12]}}, half[12], half[6:2],
                     rd, OPC_LUI};
            end
          end
          3'b100: begin
            unique case (half[11:10])
              2'b00: begin
                bad = half[12];
                res = {7'b0000000, shamt, rs1p, F3_SRL,
                       rs1p, OPC_OP_IMM};
              end
              2'b01: begin
                bad = half[12];
                res = {7'b0100000, shamt, rs1p, F3_SRL,
                       rs1p, OPC_OP_IMM};
              end
              2'b10: res = enc_i(imm6, rs1p, F3_AND,
                                 rs1p, OPC_OP_IMM);
              default: begin
                // c[12]=1 here is RV64 subw/addw
                bad = half[12];
                unique case (half[6:5])
                  2'b00: res = {7'b0100000, rdp, rs1p,
                                F3_ADD, rs1p, OPC_OP};
                  2'b01: res = {7'b0, rdp, rs1p,
                                F3_XOR, rs1p, OPC_OP};
                  2'b10: res = {7'b0, rdp, rs1p,
                                F3_OR, rs1p, OPC_OP};
                  default: res = {7'b0, rdp, rs1p,
                                  F3_AND, rs1p, OPC_OP};
                endcase
              end
            endcase
          end
          3'b101: res = enc_j({{9{jimm[11]}}, jimm}, 5'd0);
          3'b110: res = enc_b({{4{bimm[8]}}, bimm}, 5'd0,
                              rs1p, F3_BEQ);
          default: res = enc_b({{4{bimm[8]}}, bimm}, 5'd0,
                               rs1p, F3_BNE);
        endcase
      end
      Q2: begin
        unique case (f3)
          3'b000: begin
            bad = half[12];
            res = {7'b0, shamt, rd, F3_SLL,
                   rd, OPC_OP_IMM};
          end
          3'b010: begin
            bad = (rd == 5'd0);
            res = enc_i({4'b0, ulwsp}, 5'd2, F3_LW,
                        rd, OPC_LOAD);
          end
          3'b100: begin
            if (!half[12]) begin
              if (rs2 == 5'd0) begin
                bad = (rd == 5'd0);
                res = enc_i(12'd0, rd, F3_ADD,
                            5'd0, OPC_JALR);
              end else begin
                res = {7'b0, rs2, 5'd0, F3_ADD,
                       rd, OPC_OP};
              end
            end else if (rs2 == 5'd0 && rd == 5'd0) begin
              res = enc_i(12'd1, 5'd0, 3'b000,
                          5'd0, OPC_SYSTEM);
            end else if (rs2 == 5'd0) begin
              res = enc_i(12'd0, rd, F3_ADD,
                          5'd1, OPC_JALR);
            end else begin
              res = {7'b0, rs2, rd, F3_ADD, rd, OPC_OP};
            end
          end
          3'b110: res = enc_s({4'b0, uswsp}, rs2, 5'd2,
                              F3_LW, OPC_STORE);
          default: bad = 1'b1;
        endcase
      end
      default: bad = 1'b1;
    endcase
  end

  assign inst    = bad ? NOP_INST : res;
  assign illegal = bad;

endmodule

// File: rtl/rvc_fetch_aligner.sv
// Fetch aligner: word buffer, straddle stitching, RVC expansion
// and ownership of the I-cache proc_* handshake.
module rvc_fetch_aligner
  import rvc_fetch_aligner_pkg::*;
#(
  parameter logic [31:0] NOP_INST = NOP_DEFAULT
) (
  input  logic        clk,
  input  logic        proc_reset,
  input  logic        fetch_req,
  input  logic [31:0] fetch_pc,
  input  logic        flush,
  output logic        fetch_valid,
  output logic        fetch_stall,
  output logic [31:0] fetch_inst,
  output logic        fetch_is_rvc,
  output logic        fetch_illegal,
  output logic        ICACHE_ren,
  output logic        ICACHE_wen,
  output logic [29:0] ICACHE_addr,
  output logic [31:0] ICACHE_wdata,
  input  logic [31:0] ICACHE_rdata,
  input  logic        ICACHE_stall
);

  state_e      state;
  logic        buf_v, prev_v, discard;
  logic [29:0] buf_tag, prev_tag, pend_addr;
  logic [31:0] buf_word;
  logic [15:0] prev_hi;

  logic [29:0] w, w1;
  logic        buf_hit_w, buf_hit_w1, reg_straddle;
  logic        acc_w, acc_w1, need_acc, first_half;
  logic        active, req_ren, hit, wr_buf, is16;
  logic [15:0] half;
  logic [31:0] inst32, exp_inst;
  logic        exp_illegal, unused_pc0;

  assign unused_pc0   = fetch_pc[0];
  assign w            = fetch_pc[31:2];
  assign w1           = w + 30'd1;
  assign buf_hit_w    = buf_v && buf_tag == w;
  assign buf_hit_w1   = buf_v && buf_tag == w1;
  assign reg_straddle = prev_v && prev_tag == w
                        && buf_hit_w1;

  always_comb begin
    half       = '0;
    inst32     = '0;
    acc_w      = 1'b0;
    acc_w1     = 1'b0;
    first_half = 1'b0;
    if (!fetch_pc[1]) begin
      if (buf_hit_w) begin
        half   = buf_word[15:0];
        inst32 = buf_word;
      end else begin
        acc_w  = 1'b1;
        half   = ICACHE_rdata[15:0];
        inst32 = ICACHE_rdata;
      end
    end else if (buf_hit_w) begin
      half   = buf_word[31:16];
      inst32 = {ICACHE_rdata[15:0], buf_word[31:16]};
      acc_w1 = (buf_word[17:16] == 2'b11);
    end else if (reg_straddle) begin
      half   = prev_hi;
      inst32 = {buf_word[15:0], prev_hi};
    end else begin
      // upper half not buffered: a 32-bit one needs W now, W1 next
      acc_w      = 1'b1;
      half       = ICACHE_rdata[31:16];
      first_half = (ICACHE_rdata[17:16] == 2'b11);
    end
  end

  assign need_acc = acc_w | acc_w1;
  assign active   = !proc_reset && fetch_req && !flush;
  assign req_ren  = active && state != S_WAIT && need_acc;
  assign hit      = req_ren && !ICACHE_stall;
  assign wr_buf   = hit || (state == S_WAIT && !ICACHE_stall
                    && !(discard || flush));

  assign ICACHE_ren   = !proc_reset
                        && (state == S_WAIT || req_ren);
  assign ICACHE_addr  = state == S_WAIT ? pend_addr
                        : (acc_w1 ? w1 : w);
  assign ICACHE_wen   = 1'b0;
  assign ICACHE_wdata = '0;

  assign fetch_valid = active && state != S_WAIT
                       && (need_acc ? hit && !first_half : 1'b1);
  assign fetch_stall = !proc_reset && fetch_req && !fetch_valid;

  rvc_fetch_aligner_expander #(
    .NOP_INST(NOP_INST)
  ) u_rvc_expander (
    .half   (half),
    .inst   (exp_inst),
    .illegal(exp_illegal)
  );

  assign is16          = half[1:0] != 2'b11;
  assign fetch_inst    = is16 ? exp_inst : inst32;
  assign fetch_is_rvc  = is16;
  assign fetch_illegal = is16 && exp_illegal;

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state   <= S_IDLE;
      buf_v   <= 1'b0;
      prev_v  <= 1'b0;
      discard <= 1'b0;
    end else begin
      if (wr_buf) begin
        buf_word <= ICACHE_rdata;
        buf_tag  <= ICACHE_addr;
        buf_v    <= 1'b1;
        prev_v   <= buf_v;
        prev_tag <= buf_tag;
        prev_hi  <= buf_word[31:16];
      end
      if (flush) begin
        buf_v  <= 1'b0;
        prev_v <= 1'b0;
      end
      case (state)
        S_WAIT: begin
          if (flush) discard <= 1'b1;
          if (!ICACHE_stall) begin
            discard <= 1'b0;
            state   <= (discard || flush) ? S_IDLE : S_READY;
          end
        end
        default: begin
          if (flush) begin
            state <= S_IDLE;
          end else if (req_ren && ICACHE_stall) begin
            pend_addr <= ICACHE_addr;
            discard   <= 1'b0;
            state     <= S_WAIT;
          end else if (wr_buf) begin
            state <= S_READY;
          end
        end
      endcase
    end
  end

endmodule
